// File: rtl/bram_portb_arbiter_if.sv
// Requester-side bus for one port-B client: request/grant handshake plus the
// one-cycle-later response.
interface bram_portb_arbiter_if #(
    parameter int unsigned AW = 32
);
    logic          req;
    logic          gnt;
    logic [AW-1:0] addr;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/bram_portb_arbiter.sv
// Port-B arbiter for the shared instruction/data BRAM: boot/run mode, round-robin
// between CPU (c) and loader (l), range and IMEM write-protect checks, response routing.
module bram_portb_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned MEM_BYTES = 32768,
    parameter logic [31:0] IMEM_END  = 32'h0000_5000
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_portb_arbiter_if.slave   c_bus,
    bram_portb_arbiter_if.slave   l_bus,
    input  logic                  boot_done,
    output logic                  run_mode,
    output logic [3:0]            bram_web,
    output logic [AW-1:0]         bram_addrb,
    output logic [31:0]           bram_dib,
    input  logic [31:0]           bram_dob
);
    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e        state_q, state_d;
    logic          last_l_q, last_l_d;
    logic          c_rvalid_q, c_rvalid_d, l_rvalid_q, l_rvalid_d;
    logic          c_err_q, c_err_d, l_err_q, l_err_d;
    logic [31:0]   c_hold_q, c_hold_d, l_hold_q, l_hold_d;

    logic          gnt_c, gnt_l, acc_err, sel_we;
    logic [AW-1:0] sel_addr;
    logic [3:0]    sel_be;
    logic [31:0]   sel_wdata, c_rdata_cur, l_rdata_cur;
    logic          in_run;

    assign in_run   = (state_q == StRun);
    assign run_mode = in_run;

    always_comb begin
        state_d = state_q;
        if (state_q == StBoot && boot_done) begin
            state_d = StRun;
        end

        gnt_c = 1'b0;
        gnt_l = 1'b0;
        if (!rst) begin
            if (c_bus.req && in_run && l_bus.req) begin
                // Tie: the side served less recently wins.
                gnt_c = last_l_q;
                gnt_l = !last_l_q;
            end else if (c_bus.req && in_run) begin
                gnt_c = 1'b1;
            end else if (l_bus.req) begin
                gnt_l = 1'b1;
            end
        end

        last_l_d = last_l_q;
        if (gnt_c) last_l_d = 1'b0;
        if (gnt_l) last_l_d = 1'b1;

        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_be    = 4'b0000;
        sel_wdata = 32'h0;
        acc_err   = 1'b0;
        if (gnt_c) begin
            sel_addr  = c_bus.addr;
            sel_we    = c_bus.we;
            sel_be    = c_bus.be;
            sel_wdata = c_bus.wdata;
            acc_err   = (c_bus.addr >= AW'(MEM_BYTES)) ||
                        (in_run && c_bus.we && c_bus.addr < AW'(IMEM_END));
        end else if (gnt_l) begin
            sel_addr  = l_bus.addr;
            sel_we    = l_bus.we;
            sel_be    = l_bus.be;
            sel_wdata = l_bus.wdata;
            acc_err   = (l_bus.addr >= AW'(MEM_BYTES));
        end

        bram_addrb = sel_addr;
        bram_dib   = sel_wdata;
        bram_web   = (sel_we && !acc_err) ? sel_be : 4'b0000;

        // Read data arrives straight from the BRAM in the response cycle and is
        // captured into the hold register so it stays stable afterwards.
        c_rdata_cur = c_rvalid_q ? (c_err_q ? 32'h0 : bram_dob) : c_hold_q;
        l_rdata_cur = l_rvalid_q ? (l_err_q ? 32'h0 : bram_dob) : l_hold_q;

        c_rvalid_d = gnt_c;
        l_rvalid_d = gnt_l;
        c_err_d    = gnt_c ? acc_err : c_err_q;
        l_err_d    = gnt_l ? acc_err : l_err_q;
        c_hold_d   = c_rdata_cur;
        l_hold_d   = l_rdata_cur;
    end

    assign c_bus.gnt    = gnt_c;
    assign l_bus.gnt    = gnt_l;
    assign c_bus.rvalid = c_rvalid_q;
    assign l_bus.rvalid = l_rvalid_q;
    assign c_bus.err    = c_err_q;
    assign l_bus.err    = l_err_q;
    assign c_bus.rdata  = c_rdata_cur;
    assign l_bus.rdata  = l_rdata_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            last_l_q   <= 1'b1;
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            c_err_q    <= 1'b0;
            l_err_q    <= 1'b0;
            c_hold_q   <= 32'h0;
            l_hold_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            last_l_q   <= last_l_d;
            c_rvalid_q <= c_rvalid_d;
            l_rvalid_q <= l_rvalid_d;
            c_err_q    <= c_err_d;
            l_err_q    <= l_err_d;
            c_hold_q   <= c_hold_d;
            l_hold_q   <= l_hold_d;
        end
    end
endmodule

// File: doc/bram_portb_arbiter.md
Name: bram_portb_arbiter

Overview:
- Shares port B of the unified instruction/data BRAM between two requesters: the CPU load/store unit (C) and the UART program loader/debug master (L).
- Port A stays dedicated to instruction fetch.
- Owns the boot/run mode FSM, round-robin arbitration, address-range and IMEM write-protection checks, and routes the 1-cycle read response back to the owning requester.

Parameters:
- MEM_BYTES, 32768, total BRAM bytes; legal byte addresses are 0..MEM_BYTES-1.
- IMEM_END, 32'h00005000, first byte address above the instruction region.
- AW, 32, address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  CPU request valid.
- c_gnt  out  1  CPU request accepted this cycle (combinational).
- c_addr  in  AW  CPU byte address.
- c_we  in  1  CPU write.
- c_be  in  4  CPU byte enables.
- c_wdata  in  32  CPU write data.
- c_rvalid  out  1  CPU response valid.
- c_rdata  out  32  CPU read data.
- c_err  out  1  CPU response error.
- l_req, l_gnt, l_addr, l_we, l_be, l_wdata, l_rvalid, l_rdata, l_err: loader equivalents, same widths and meanings.
- boot_done  in  1  loader pulse: image load complete.
- run_mode  out  1  0 = BOOT, 1 = RUN.
- bram_web  out  4  port-B byte write enables.
- bram_addrb  out  AW  port-B byte address.
- bram_dib  out  32  port-B write data.
- bram_dob  in  32  port-B read data; read-first, valid the cycle after the address edge.

Behaviour:
- **Mode FSM**
  - States are BOOT and RUN; reset enters BOOT.
  - BOOT -> RUN on the clock edge where boot_done=1.
  - boot_done is ignored in RUN. RUN exits only via rst.
  - run_mode is registered: run_mode=1 from the cycle after the boot_done edge.
- **Eligibility**
  - BOOT: only L is eligible; c_gnt=0.
  - RUN: both C and L are eligible.
- **Arbitration**
  - Combinational grant; one grant per cycle max.
  - Single requester eligible: that requester is granted.
  - Both eligible: grant the requester not granted most recently.
  - last_ptr register updates on every grant. Reset value = L, so C wins the first tie.
  - c_gnt/l_gnt = 0 while rst=1.
- **Access check on the granted request**
  - err if addr >= MEM_BYTES.
  - err if C, RUN, c_we=1 and addr < IMEM_END (IMEM write protect).
  - L writes are never protected.
  - Reads of IMEM are always legal.
- **BRAM drive, same cycle as grant**
  - bram_addrb = granted addr.
  - bram_dib = granted wdata.
  - bram_web = be if (we && !err), else 4'b0000.
  - No grant: bram_web=0, bram_addrb=0, bram_dib=0.
  - addr[1:0] is passed through unchanged; the BRAM word-aligns. Sub-word lane placement is the requester's job.
- **Response**
  - Exactly one cycle after grant, the owner's rvalid=1 for one cycle.
  - rdata = bram_dob if no err; rdata = 0 if err.
  - err is registered with the grant.
  - Writes also return rvalid; rdata = old word (read-first) unless err.
  - Response outputs (rdata, err) are registered and hold their value while rvalid=0. The non-owner's rvalid=0.
- **Throughput**
  - Back-to-back accepts are allowed every cycle, no bubbles.
  - Under sustained contention the two requesters alternate.
- **Boundaries**
  - Loader access granted in the boot_done cycle: its response still returns to L next cycle.
  - C may be granted from the first RUN cycle.
  - Address exactly IMEM_END-1 for a C write in RUN -> err. Address IMEM_END -> ok.
  - Address exactly MEM_BYTES -> err. Address MEM_BYTES-4 -> ok.
  - req deasserted with no grant: no state change except the FSM.
- **Reset values**
  - c_rvalid = l_rvalid = 0; c_rdata = l_rdata = 0; c_err = l_err = 0.
  - run_mode = 0; last_ptr = L.
  - Reset mid-transaction drops the pending response; no rvalid is issued in the cycle after rst.

Test Plan:
1. BOOT, c_req=1 with l_req=1 (l_we=1, addr 0x0, be F, data 0xDEADBEEF) -> c_gnt=0, l_gnt=1, bram_web=F; next cycle l_rvalid=1, l_err=0.
2. RUN, C and L both request reads every cycle for 4 cycles -> grants C, L, C, L; each rvalid lands 1 cycle later, routed to the right owner, with rdata = bram_dob.
3. RUN, C write to 0x4FFC -> bram_web=0, c_err=1, c_rdata=0. C write to 0x5000 be=4'b0011 -> bram_web=0011, c_err=0. L write to 0x0 -> allowed.
4. L read at 0x8000 -> l_err=1, l_rdata=0. L read at 0x7FFC -> l_err=0.
5. boot_done pulse in the same cycle as an L grant -> l_rvalid next cycle, run_mode=1 next cycle, C granted in that cycle.
6. rst asserted the cycle after a grant -> c_rvalid=0 and l_rvalid=0, run_mode=0, next tie goes to C.
